demux32_1to4_buffered: RTL and testbench

- Inverse of the 32-bit 4:1 multiplexer path: routes one 32-bit input stream to one of four output channels, selected per word.
- Each channel has a one-entry holding register with a valid/ready handshake, so a stalled consumer blocks only words aimed at it.
- Sits after the datapath select logic. It fans results out to four downstream consumers and keeps a per-channel delivered-word count for debug.

---
 rtl/demux_pkg.sv | 23 ++
 rtl/demux_slot.sv | 46 ++++
 rtl/demux32_1to4_buffered.sv | 45 ++++
 tb/tb_demux32_1to4_buffered.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared sizes and bus slicing helpers for the buffered 1-to-4 demux
package demux_pkg;

    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;
    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;

    function automatic logic [WIDTH_DEF-1:0] get_word(
        input logic [NUM_CH*WIDTH_DEF-1:0] bus,
        input logic [SEL_W-1:0]            k
    );
        return bus[k*WIDTH_DEF +: WIDTH_DEF];
    endfunction

    function automatic logic [CNT_W_DEF-1:0] get_count(
        input logic [NUM_CH*CNT_W_DEF-1:0] bus,
        input logic [SEL_W-1:0]            k
    );
        return bus[k*CNT_W_DEF +: CNT_W_DEF];
    endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register with valid flag and delivered-word counter
module demux_slot #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             xfer;

    // A load may coincide with a delivery; the new word replaces the old one and valid stays set
    always_comb begin
        xfer    = valid_q & out_ready;
        data_d  = load ? load_data : data_q;
        valid_d = load | (valid_q & ~out_ready);
        count_d = count_q + CNT_W'(xfer);
    end

    // Slot state; reset discards any held word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign count     = count_q;

endmodule

// File: rtl/demux32_1to4_buffered.sv
// demux32_1to4_buffered: routes one input stream to four independently back-pressured channels
module demux32_1to4_buffered
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*CNT_W-1:0] out_count
);

    logic [NUM_CH-1:0] load;

    // Readiness looks only at the selected slot and never at in_valid, so upstream sees no loop
    always_comb begin
        in_ready     = ~out_valid[in_sel] | out_ready[in_sel];
        load         = '0;
        load[in_sel] = in_valid & in_ready;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH),
            .CNT_W(CNT_W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[k]),
            .load_data(in_data),
            .out_ready(out_ready[k]),
            .out_data (out_data[k*WIDTH +: WIDTH]),
            .out_valid(out_valid[k]),
            .count    (out_count[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_demux32_1to4_buffered.sv
// tb_demux32_1to4_buffered: table-driven and directed checks of the buffered demux
module tb_demux32_1to4_buffered;
    import demux_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [31:0]  in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [63:0]  out_count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [31:0] d;
        logic [3:0]  ordy;
        logic        rdy;
        logic [3:0]  vld;
        logic [1:0]  ch;
        logic [31:0] xd;
    } vec_t;

    vec_t vecs[14];

    demux32_1to4_buffered dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counts(input string name, input logic [15:0] c0, input logic [15:0] c1,
                              input logic [15:0] c2, input logic [15:0] c3);
        chk({name, "_c0"}, 128'(get_count(out_count, 2'd0)), 128'(c0));
        chk({name, "_c1"}, 128'(get_count(out_count, 2'd1)), 128'(c1));
        chk({name, "_c2"}, 128'(get_count(out_count, 2'd2)), 128'(c2));
        chk({name, "_c3"}, 128'(get_count(out_count, 2'd3)), 128'(c3));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'd0, 32'hAAAAAAAA, 4'hF,    1'b1, 4'b0001, 2'd0, 32'hAAAAAAAA};
        vecs[1]  = '{1'b1, 2'd1, 32'h55555555, 4'hF,    1'b1, 4'b0010, 2'd1, 32'h55555555};
        vecs[2]  = '{1'b1, 2'd2, 32'h00000000, 4'hF,    1'b1, 4'b0100, 2'd2, 32'h00000000};
        vecs[3]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 4'hF,    1'b1, 4'b1000, 2'd3, 32'hFFFFFFFF};
        vecs[4]  = '{1'b0, 2'd0, 32'h0,        4'hF,    1'b1, 4'b0000, 2'd3, 32'hFFFFFFFF};
        vecs[5]  = '{1'b1, 2'd2, 32'h12345678, 4'b1011, 1'b1, 4'b0100, 2'd2, 32'h12345678};
        vecs[6]  = '{1'b1, 2'd2, 32'h9ABCDEF0, 4'b1011, 1'b0, 4'b0100, 2'd2, 32'h12345678};
        vecs[7]  = '{1'b1, 2'd0, 32'h0BADF00D, 4'b1011, 1'b1, 4'b0101, 2'd0, 32'h0BADF00D};
        vecs[8]  = '{1'b1, 2'd2, 32'h9ABCDEF0, 4'hF,    1'b1, 4'b0100, 2'd2, 32'h9ABCDEF0};
        vecs[9]  = '{1'b0, 2'd2, 32'h0,        4'hF,    1'b1, 4'b0000, 2'd2, 32'h9ABCDEF0};
        vecs[10] = '{1'b1, 2'd1, 32'h11111111, 4'hF,    1'b1, 4'b0010, 2'd1, 32'h11111111};
        vecs[11] = '{1'b1, 2'd1, 32'hCAFEBABE, 4'hF,    1'b1, 4'b0010, 2'd1, 32'hCAFEBABE};
        vecs[12] = '{1'b0, 2'd1, 32'h0,        4'h0,    1'b0, 4'b0010, 2'd1, 32'hCAFEBABE};
        vecs[13] = '{1'b0, 2'd0, 32'h0,        4'hF,    1'b1, 4'b0000, 2'd1, 32'hCAFEBABE};

        rst_n     = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_valid", 128'(out_valid), 128'h0);
        chk("rst_data", out_data, 128'h0);
        chk("rst_count", 128'(out_count), 128'h0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("rst_in_ready_sel%0d", s), 128'(in_ready), 128'h1);
        end
        tick();

        for (int i = 0; i < 14; i++) begin
            in_valid  = vecs[i].v;
            in_sel    = vecs[i].sel;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 128'(in_ready), 128'(vecs[i].rdy));
            tick();
            chk($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].vld));
            chk($sformatf("v%0d_data_ch%0d", i, vecs[i].ch), 128'(get_word(out_data, vecs[i].ch)),
                128'(vecs[i].xd));
            if (i == 4) chk_counts("after_fanout", 16'd1, 16'd1, 16'd1, 16'd1);
            if (i == 9) chk_counts("after_stall", 16'd2, 16'd1, 16'd3, 16'd1);
        end
        chk_counts("after_replace", 16'd2, 16'd3, 16'd3, 16'd1);

        out_ready = 4'hF;
        in_sel    = 2'd3;
        in_valid  = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            in_data = 32'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk_counts("preload", 16'd2, 16'd3, 16'd3, 16'hFFFF);
        chk("preload_valid", 128'(out_valid), 128'h0);
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        chk("wrap_pre_valid", 128'(out_valid), 128'h8);
        tick();
        chk("wrap_count3", 128'(get_count(out_count, 2'd3)), 128'h0);

        out_ready = 4'b0110;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 32'h0000C0DE;
        tick();
        in_sel  = 2'd3;
        in_data = 32'h3333C0DE;
        tick();
        in_valid = 1'b0;
        chk("stall_valid", 128'(out_valid), 128'h9);
        chk("stall_data3", 128'(get_word(out_data, 2'd3)), 128'h3333C0DE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 128'(out_valid), 128'h0);
        chk("async_rst_count", 128'(out_count), 128'h0);
        chk("async_rst_data", out_data, 128'h0);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("post_rst_in_ready_sel%0d", s), 128'(in_ready), 128'h1);
        end
        out_ready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_valid%0d", i), 128'(out_valid), 128'h0);
        end
        chk("post_rst_count", 128'(out_count), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
